// File: rtl/umi_initiator.sv
// -----------------------------------------------------------------------------
// umi_initiator
//   Turns one local host request (read, acked write or posted write) into a
//   single UMI request transaction. For reads and acked writes it then waits
//   for the matching UMI response, with a timeout. Only one transaction can be
//   in flight at a time.
//
// Ports
//   clk, nreset          : single clock, asynchronous active-low reset
//   host_read/write/posted: request strobes, sampled only while host_ready=1
//   host_addr/srcaddr    : target address / return address
//   host_size/len        : UMI size and len fields
//   host_wrdata          : write payload
//   host_ready           : block idle, strobes are accepted this cycle
//   host_done            : one-cycle completion pulse
//   host_rddata          : read data, valid together with host_done for reads
//   host_err             : [0] bad response opcode/address, [1] timeout
//   uhost_req_*          : UMI request channel (valid/ready)
//   uhost_resp_*         : UMI response channel (valid/ready)
//
// Handshake: a transfer occurs on a rising clk edge where valid and ready are
// both 1. Once valid is raised, the payload holds steady until that edge.
// -----------------------------------------------------------------------------
module umi_initiator #(
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int DW      = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          host_read,
  input  logic          host_write,
  input  logic          host_posted,
  input  logic [AW-1:0] host_addr,
  input  logic [AW-1:0] host_srcaddr,
  input  logic [2:0]    host_size,
  input  logic [7:0]    host_len,
  input  logic [DW-1:0] host_wrdata,
  output logic          host_ready,
  output logic          host_done,
  output logic [DW-1:0] host_rddata,
  output logic [1:0]    host_err,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] OP_POSTED = 2'd3;

  // Counter value seen in the TIMEOUT-th waiting cycle.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t          state, state_next;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q, srcaddr_q;
  logic [2:0]      size_q;
  logic [7:0]      len_q;
  logic [DW-1:0]   wrdata_q, rddata_q;
  logic [15:0]     cnt_q;

  logic            accept, req_fire, resp_fire, timeout_hit;
  logic [4:0]      req_opcode, resp_opcode_exp;
  logic            resp_bad;

  // Response source address and upper command bits carry nothing we check.
  logic            unused_resp;
  assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5]};

  assign accept      = (state == IDLE) && (host_read || host_write || host_posted);
  assign req_fire    = (state == REQ) && uhost_req_ready;
  assign resp_fire   = (state == RESP) && uhost_resp_valid;
  // A response in the same cycle takes precedence over the timeout.
  assign timeout_hit = (state == RESP) && !uhost_resp_valid && (cnt_q == TIMEOUT_LAST);

  assign resp_opcode_exp = (op_q == OP_READ) ? 5'h02 : 5'h04;
  assign resp_bad = (uhost_resp_cmd[4:0] != resp_opcode_exp) ||
                    (uhost_resp_dstaddr != srcaddr_q);

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ:  if (req_fire) state_next = (op_q == OP_POSTED) ? IDLE : RESP;
      RESP: if (resp_fire || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    host_ready       = (state == IDLE);
    uhost_req_valid  = (state == REQ);
    uhost_resp_ready = (state != REQ);
    host_done        = 1'b0;
    host_err         = 2'b00;
    host_rddata      = rddata_q;
    if (req_fire && (op_q == OP_POSTED)) begin
      host_done = 1'b1;
    end else if (resp_fire) begin
      host_done = 1'b1;
      host_err  = {1'b0, resp_bad};
      // Forward read data so it is valid in the same cycle as host_done.
      if (op_q == OP_READ) host_rddata = uhost_resp_data;
    end else if (timeout_hit) begin
      host_done = 1'b1;
      host_err  = 2'b10;
    end
  end

  // Request payload built from the captured fields
  always_comb begin
    case (op_q)
      OP_READ:   req_opcode = 5'h01;
      OP_WRITE:  req_opcode = 5'h03;
      OP_POSTED: req_opcode = 5'h05;
      default:   req_opcode = 5'h00;
    endcase
    uhost_req_cmd        = '0;
    uhost_req_cmd[4:0]   = req_opcode;
    uhost_req_cmd[7:5]   = size_q;
    uhost_req_cmd[15:8]  = len_q;
    uhost_req_cmd[22]    = 1'b1;
    uhost_req_dstaddr    = addr_q;
    uhost_req_srcaddr    = srcaddr_q;
    uhost_req_data       = (op_q == OP_READ) ? '0 : wrdata_q;
  end

  // Captured request fields, read data and timeout counter
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      op_q      <= OP_NONE;
      addr_q    <= '0;
      srcaddr_q <= '0;
      size_q    <= '0;
      len_q     <= '0;
      wrdata_q  <= '0;
      rddata_q  <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        op_q      <= host_read ? OP_READ : (host_write ? OP_WRITE : OP_POSTED);
        addr_q    <= host_addr;
        srcaddr_q <= host_srcaddr;
        size_q    <= host_size;
        len_q     <= host_len;
        wrdata_q  <= host_wrdata;
      end
      if (resp_fire && (op_q == OP_READ)) rddata_q <= uhost_resp_data;
      if (req_fire) cnt_q <= '0;
      else if ((state == RESP) && !uhost_resp_valid && !timeout_hit) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: doc/umi_initiator.md
UMI_INITIATOR -- requirements
Module: umi_initiator

Interface
REQ-001 Parameters SHALL be: CW, 32, command width; AW, 64, address width; DW, 256, data width; TIMEOUT, 1023, response wait limit in cycles (1..65535).
REQ-002 Clock and reset ports SHALL be: clk input 1 clock; nreset input 1 async active-low reset. The block uses one clock only.
REQ-003 Local request ports SHALL be: host_read input 1 read request; host_write input 1 acked write request; host_posted input 1 posted write request; host_addr input AW target address; host_srcaddr input AW return address; host_size input 3 size; host_len input 8 len; host_wrdata input DW write data.
REQ-004 Local status ports SHALL be: host_ready output 1 block idle and able to accept; host_done output 1 single-cycle completion pulse; host_rddata output DW read data; host_err output 2 completion error flags.
REQ-005 UMI request ports SHALL be: uhost_req_valid output 1; uhost_req_cmd output CW; uhost_req_dstaddr output AW; uhost_req_srcaddr output AW; uhost_req_data output DW; uhost_req_ready input 1.
REQ-006 UMI response ports SHALL be: uhost_resp_valid input 1; uhost_resp_cmd input CW; uhost_resp_dstaddr input AW; uhost_resp_srcaddr input AW; uhost_resp_data input DW; uhost_resp_ready output 1.

Function
REQ-007 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-008 host_ready SHALL equal (state==IDLE).
REQ-009 Accept rule: in IDLE, when any of host_read/host_write/host_posted is high, the block SHALL accept the request, capture all host_* inputs, and enter REQ on the next cycle.
REQ-010 Multiple accepted strobes SHALL resolve by priority read > write > posted.
REQ-011 uhost_req_cmd SHALL be built from the captured fields: opcode[4:0] (read 5'h01, write 5'h03, posted 5'h05); size[7:5]; len[15:8]; eom[22]=1; all other bits 0.
REQ-012 uhost_req_dstaddr SHALL be the captured host_addr; uhost_req_srcaddr the captured host_srcaddr; uhost_req_data the captured host_wrdata for writes and 0 for reads.
REQ-013 In REQ, uhost_req_valid SHALL be 1 and all uhost_req_* outputs SHALL be stable until the cycle where uhost_req_ready=1.
REQ-014 On the REQ handshake, a read or acked write SHALL go to RESP and clear the timeout counter.
REQ-015 On the REQ handshake, a posted write SHALL return to IDLE with host_done=1 and host_err=0 in the handshake cycle.
REQ-016 uhost_resp_ready SHALL be 1 in RESP and in IDLE, and 0 in REQ.
REQ-017 A response arriving in IDLE SHALL be consumed and discarded, with no host_done.
REQ-018 In RESP, a response handshake SHALL drive host_done=1 for one cycle, with the FSM in IDLE on the next cycle.
REQ-019 On the RESP handshake, host_rddata SHALL load uhost_resp_data for reads; for writes it SHALL hold its previous value.
REQ-020 host_err[0] SHALL be 1 when the response opcode (uhost_resp_cmd[4:0]) is not the expected value (read 5'h02, write 5'h04), or when uhost_resp_dstaddr differs from the captured host_srcaddr.
REQ-021 Timeout: the counter SHALL increment in RESP each cycle without a response. When it reaches TIMEOUT, the block SHALL pulse host_done with host_err=2'b10 and return to IDLE.
REQ-022 If the response handshake and counter==TIMEOUT occur in the same cycle, the response SHALL win.
REQ-023 host_err SHALL be valid only while host_done=1 and SHALL be 0 otherwise.
REQ-024 host_* strobes presented while host_ready=0 SHALL be ignored; they are not queued.
REQ-025 At most one transaction SHALL be outstanding at any time.

Reset
REQ-026 While nreset=0, the FSM SHALL be IDLE and uhost_req_valid, host_done, host_err, host_rddata, the captured fields and the counter SHALL all be 0.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately with no host_done. A late response after reset release SHALL be discarded per REQ-017.

Verification
REQ-028 Read, ready tied 1: host_read, addr 0x1000, srcaddr 0x80, size 3, len 0 -> cmd 0x0040_0061 with dstaddr 0x1000 issued the next cycle; resp opcode 0x02, dstaddr 0x80, data 0xA5 -> host_done=1, host_rddata=0xA5, host_err=0.
REQ-029 Backpressure: uhost_req_ready low for 5 cycles -> valid held high with cmd/addr/data unchanged; exactly one handshake; host_ready=0 throughout.
REQ-030 Posted write data 0xDEAD -> host_done in the handshake cycle, no RESP state entered; a later unsolicited response is discarded without host_done.
REQ-031 Acked write answered with opcode 0x02 -> host_done=1, host_err=2'b01.
REQ-032 TIMEOUT=8, no response -> host_done at the 8th RESP cycle with host_err=2'b10; a response arriving after that is discarded; reset pulsed mid-REQ -> valid drops immediately and no host_done.
